// File: rtl/modulo_vga_controller_if.sv
// Pin-level bundle of the display block: VGA timing/colour, SDRAM control and FSM debug.
// outRequest is a valid with no ready: the pixel at (outX,outY) is consumed in the cycle it is shown.
`timescale 1ns/1ps
interface modulo_vga_controller_if;
  logic        outRequest;
  logic [9:0]  outX;
  logic [9:0]  outY;
  logic        VGA_CLK;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        DRAM_CLK;
  logic        DRAM_CKE;
  logic        DRAM_CS_N;
  logic        DRAM_RAS_N;
  logic        DRAM_CAS_N;
  logic        DRAM_WE_N;
  logic [12:0] DRAM_ADDR;
  logic [1:0]  DRAM_BA;
  logic [1:0]  DRAM_DQM;
  logic [3:0]  dbg_sdram_state;

  modport master (
    output outRequest, outX, outY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
           VGA_R, VGA_G, VGA_B, DRAM_CLK, DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N,
           DRAM_WE_N, DRAM_ADDR, DRAM_BA, DRAM_DQM, dbg_sdram_state
  );
  modport slave (
    input outRequest, outX, outY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
          VGA_R, VGA_G, VGA_B, DRAM_CLK, DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N,
          DRAM_WE_N, DRAM_ADDR, DRAM_BA, DRAM_DQM, dbg_sdram_state
  );
endinterface

// File: rtl/modulo_vga_controller.sv
// 640x480@60 VGA timing with a button-steered paddle, plus SDRAM init/refresh keeper.
// Single CLOCK_50 domain; KEY[0] is the asynchronous active-low reset.
`timescale 1ns/1ps
module modulo_vga_controller #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int PADDLE_W       = 64,
  parameter int PADDLE_Y       = 440,
  parameter int PADDLE_H       = 16,
  parameter int STEP           = 8,
  parameter int INIT_WAIT      = 10000,
  parameter int REFRESH_PERIOD = 390
) (
  input  logic        CLOCK_50,
  input  logic [2:0]  KEY,
  inout  wire  [15:0] DRAM_DQ,
  modulo_vga_controller_if.master bus
);
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PADDLE_MAX = H_ACTIVE - PADDLE_W;
  localparam int T_RP       = 3;
  localparam int T_RC       = 7;
  localparam int T_MRD      = 2;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  logic rst_n;
  assign rst_n = KEY[0];

  // ---------------- pixel timing ----------------
  logic       vga_clk_q;
  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  // The pixel-enable is the cycle in which VGA_CLK falls.
  assign pix_en = vga_clk_q;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      vga_clk_q <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
    end else begin
      vga_clk_q <= ~vga_clk_q;
      if (pix_en) begin
        if (h_cnt == 10'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // ---------------- buttons and paddle ----------------
  logic [1:0]  key_s1, key_s2, key_s3;
  logic        req_right, req_left;
  logic [9:0]  target, target_n, paddle_x;
  logic [10:0] right_sum;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_s1   <= 2'b11;
      key_s2   <= 2'b11;
      key_s3   <= 2'b11;
      target   <= 10'(PADDLE_MAX / 2);
      paddle_x <= 10'(PADDLE_MAX / 2);
    end else begin
      key_s1 <= KEY[2:1];
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      target <= target_n;
      // Paddle only moves at the start of vertical blank so a frame never tears.
      if (pix_en && h_cnt == 10'd0 && v_cnt == 10'(V_ACTIVE))
        paddle_x <= target;
    end
  end

  assign req_right = key_s3[0] & ~key_s2[0];
  assign req_left  = key_s3[1] & ~key_s2[1];
  assign right_sum = {1'b0, target} + 11'(STEP);

  always_comb begin
    target_n = target;
    if (req_right && !req_left)
      target_n = (right_sum > 11'(PADDLE_MAX)) ? 10'(PADDLE_MAX) : right_sum[9:0];
    else if (req_left && !req_right)
      target_n = (target < 10'(STEP)) ? '0 : target - 10'(STEP);
  end

  // ---------------- video outputs ----------------
  logic        active, on_paddle;
  logic [10:0] paddle_end;

  assign active     = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign paddle_end = {1'b0, paddle_x} + 11'(PADDLE_W - 1);
  assign on_paddle  = (v_cnt >= 10'(PADDLE_Y)) && (v_cnt < 10'(PADDLE_Y + PADDLE_H)) &&
                      (h_cnt >= paddle_x) && ({1'b0, h_cnt} <= paddle_end);

  assign bus.outRequest  = active;
  assign bus.VGA_BLANK_N = active;
  assign bus.outX        = h_cnt;
  assign bus.outY        = v_cnt;
  assign bus.VGA_CLK     = vga_clk_q;
  assign bus.VGA_SYNC_N  = 1'b0;
  assign bus.VGA_HS      = !((h_cnt >= 10'(H_ACTIVE + H_FP)) && (h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign bus.VGA_VS      = !((v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC)));

  always_comb begin
    {bus.VGA_R, bus.VGA_G, bus.VGA_B} = 24'h000000;
    if (active)
      {bus.VGA_R, bus.VGA_G, bus.VGA_B} = on_paddle ? 24'hFFFFFF : 24'h000080;
  end

  // ---------------- SDRAM init and refresh ----------------
  typedef enum logic [3:0] {
    S_INIT_WAIT, S_PRECHARGE, S_WAIT_RP, S_REFRESH, S_WAIT_RC,
    S_LOAD_MODE, S_WAIT_MRD, S_IDLE, S_AUTO_REFRESH
  } sd_state_t;

  sd_state_t   state, state_n;
  logic [13:0] sd_cnt, sd_cnt_n;
  logic [2:0]  ref_cnt, ref_cnt_n;
  logic [3:0]  cmd;
  logic [12:0] addr;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT_WAIT;
      sd_cnt  <= '0;
      ref_cnt <= '0;
    end else begin
      state   <= state_n;
      sd_cnt  <= sd_cnt_n;
      ref_cnt <= ref_cnt_n;
    end
  end

  // Wait states count the NOPs between commands, so each limit is (t - 2).
  always_comb begin
    state_n   = state;
    sd_cnt_n  = sd_cnt + 14'd1;
    ref_cnt_n = ref_cnt;
    cmd       = CMD_NOP;
    addr      = '0;
    unique case (state)
      S_INIT_WAIT: if (sd_cnt == 14'(INIT_WAIT - 1)) begin state_n = S_PRECHARGE; sd_cnt_n = '0; end
      S_PRECHARGE: begin
        cmd      = CMD_PRE;
        addr     = 13'h0400;
        state_n  = S_WAIT_RP;
        sd_cnt_n = '0;
      end
      S_WAIT_RP: if (sd_cnt == 14'(T_RP - 2)) begin
        state_n   = S_REFRESH;
        sd_cnt_n  = '0;
        ref_cnt_n = '0;
      end
      S_REFRESH: begin
        cmd      = CMD_REF;
        state_n  = S_WAIT_RC;
        sd_cnt_n = '0;
      end
      S_WAIT_RC: if (sd_cnt == 14'(T_RC - 2)) begin
        sd_cnt_n = '0;
        if (ref_cnt == 3'd7) begin
          state_n = S_LOAD_MODE;
        end else begin
          state_n   = S_REFRESH;
          ref_cnt_n = ref_cnt + 3'd1;
        end
      end
      S_LOAD_MODE: begin
        cmd      = CMD_LMR;
        addr     = 13'h0030;
        state_n  = S_WAIT_MRD;
        sd_cnt_n = '0;
      end
      S_WAIT_MRD: if (sd_cnt == 14'(T_MRD - 2)) begin state_n = S_IDLE; sd_cnt_n = '0; end
      S_IDLE: if (sd_cnt == 14'(REFRESH_PERIOD - 2)) begin state_n = S_AUTO_REFRESH; sd_cnt_n = '0; end
      S_AUTO_REFRESH: begin
        cmd      = CMD_REF;
        state_n  = S_IDLE;
        sd_cnt_n = '0;
      end
      default: begin
        state_n  = S_INIT_WAIT;
        sd_cnt_n = '0;
      end
    endcase
  end

  assign {bus.DRAM_CS_N, bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N} = cmd;
  assign bus.DRAM_ADDR       = addr;
  assign bus.DRAM_CLK        = ~CLOCK_50;
  assign bus.DRAM_CKE        = 1'b1;
  assign bus.DRAM_BA         = 2'b00;
  assign bus.DRAM_DQM        = 2'b11;
  assign bus.dbg_sdram_state = state;
  assign DRAM_DQ             = 16'hzzzz;
endmodule

// File: tb/tb_modulo_vga_controller.sv
// Directed bench for modulo_vga_controller with a shortened vertical frame (7 lines)
// so paddle updates, which only happen once per frame, fit in a short run.
`timescale 1ns/1ps
module tb_modulo_vga_controller;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int PADDLE_Y = 1;
  localparam int PADDLE_H = 2;
  localparam int H_TOTAL  = 800;
  localparam int FRAME    = 7 * 1600;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [23:0] BLUE  = 24'h000080;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic [2:0] key = 3'b110;
  wire [15:0] dram_dq;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= key[0] ? cyc + 1 : 0;

  modulo_vga_controller_if vif ();

  modulo_vga_controller #(
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PADDLE_Y(PADDLE_Y), .PADDLE_H(PADDLE_H)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .DRAM_DQ (dram_dq),
    .bus     (vif)
  );

  logic [3:0]  sd_cmd;
  logic [23:0] rgb;
  assign sd_cmd = {vif.DRAM_CS_N, vif.DRAM_RAS_N, vif.DRAM_CAS_N, vif.DRAM_WE_N};
  assign rgb    = {vif.VGA_R, vif.VGA_G, vif.VGA_B};

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  int          exp_t[$];
  logic [16:0] got_q[$];
  int          got_t[$];

  always @(negedge clk)
    if (key[0] && sd_cmd != CMD_NOP) begin
      got_q.push_back({sd_cmd, vif.DRAM_ADDR});
      got_t.push_back(cyc);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_xy(input int x, input int y);
    int n;
    bit found;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      found = (32'(vif.outX) == x) && (32'(vif.outY) == y);
    end while (!found && n < 30000);
    check("wait_xy_reached", 32'(found), 1);
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] exp_rgb, input bit exp_act);
    wait_xy(x, y);
    check("pix_rgb", 32'(rgb), 32'(exp_rgb));
    check("pix_blank_n", 32'(vif.VGA_BLANK_N), 32'(exp_act));
    check("pix_request", 32'(vif.outRequest), 32'(exp_act));
  endtask

  // Scan one whole paddle line; returns first/last white column.
  task automatic measure(output int first, output int last);
    int bad;
    first = -1;
    last  = -1;
    bad   = 0;
    wait_xy(0, PADDLE_Y);
    for (int i = 0; i < 2 * H_TOTAL; i++) begin
      if (i > 0) @(negedge clk);
      if (vif.outRequest) begin
        if (rgb == WHITE) begin
          if (first < 0) first = 32'(vif.outX);
          last = 32'(vif.outX);
        end else if (rgb != BLUE) begin
          bad++;
        end
      end
    end
    check("legal_colours", bad, 0);
  endtask

  task automatic expect_paddle(input string tag, input int x);
    int f, l;
    measure(f, l);
    check({tag, "_first"}, f, x);
    check({tag, "_last"}, l, x + 63);
  endtask

  // which[0] = right (KEY[1]), which[1] = left (KEY[2])
  task automatic press(input logic [1:0] which, input int hold);
    @(negedge clk);
    key[2:1] = ~which;
    repeat (hold) @(negedge clk);
    key[2:1] = 2'b11;
    repeat (hold) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 key[0] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_hs;
    int prev_t;
    logic [16:0] g;
    int gt;

    // reset state
    repeat (5) @(negedge clk);
    check("rst_x", 32'(vif.outX), 0);
    check("rst_y", 32'(vif.outY), 0);
    check("rst_vga_clk", 32'(vif.VGA_CLK), 0);
    check("rst_cmd", 32'(sd_cmd), 32'(CMD_NOP));
    check("rst_sd_state", 32'(vif.dbg_sdram_state), 0);
    check("rst_cke", 32'(vif.DRAM_CKE), 1);
    check("rst_dqm", 32'(vif.DRAM_DQM), 3);
    check("rst_ba", 32'(vif.DRAM_BA), 0);
    check("sync_n", 32'(vif.VGA_SYNC_N), 0);
    check("dram_clk", 32'(vif.DRAM_CLK), 1);
    check("rst_blank_n", 32'(vif.VGA_BLANK_N), 1);
    check("rst_rgb", 32'(rgb), 32'(BLUE));
    #1 key[0] = 1'b1;

    // line / frame timing and default paddle at 288
    pix(300, 0, BLUE, 1);
    wait_xy(655, 0);
    check("hs_655", 32'(vif.VGA_HS), 1);
    wait_xy(656, 0);
    t_hs = cyc;
    check("hs_656", 32'(vif.VGA_HS), 0);
    check("hblank_rgb", 32'(rgb), 32'(BLACK));
    check("hblank_blank_n", 32'(vif.VGA_BLANK_N), 0);
    check("vga_clk_lo", 32'(vif.VGA_CLK), 0);
    @(negedge clk);
    check("vga_clk_hi", 32'(vif.VGA_CLK), 1);
    wait_xy(751, 0);
    check("hs_751", 32'(vif.VGA_HS), 0);
    wait_xy(752, 0);
    check("hs_752", 32'(vif.VGA_HS), 1);
    pix(287, 1, BLUE, 1);
    pix(288, 1, WHITE, 1);
    wait_xy(656, 1);
    check("line_period", cyc - t_hs, 1600);
    pix(351, 2, WHITE, 1);
    pix(352, 2, BLUE, 1);
    pix(288, 3, BLUE, 1);
    pix(639, 3, BLUE, 1);
    pix(640, 3, BLACK, 0);
    pix(0, 4, BLACK, 0);
    check("vs_4", 32'(vif.VGA_VS), 1);
    wait_xy(0, 5);
    check("vs_5", 32'(vif.VGA_VS), 0);
    wait_xy(0, 6);
    check("vs_6", 32'(vif.VGA_VS), 1);
    wait_xy(0, 0);
    check("frame_period", cyc, FRAME);

    // SDRAM power-up sequence
    repeat (200) @(negedge clk);
    exp_q.push_back({CMD_PRE, 13'h0400}); exp_t.push_back(10000);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({CMD_REF, 13'h0000}); exp_t.push_back(10003 + 7 * i);
    end
    exp_q.push_back({CMD_LMR, 13'h0030}); exp_t.push_back(10059);
    while (exp_q.size() > 0) begin
      check("sd_cmd_present", 32'(got_q.size() > 0), 1);
      if (got_q.size() == 0) break;
      g  = got_q.pop_front();
      gt = got_t.pop_front();
      check("sd_cmd", 32'(g), 32'(exp_q.pop_front()));
      check("sd_time", gt, exp_t.pop_front());
    end
    check("ar_count", 32'(got_q.size() >= 3), 1);
    prev_t = 10059;
    for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
      g  = got_q.pop_front();
      gt = got_t.pop_front();
      check("ar_cmd", 32'(g), 32'({CMD_REF, 13'h0000}));
      if (i == 0) check("ar_first_window", 32'(gt > 10060 && gt <= 10059 + 392), 1);
      else        check("ar_spacing", gt - prev_t, 390);
      prev_t = gt;
    end

    // one right press moves the paddle at the next vertical blank
    expect_paddle("pad_default", 288);
    press(2'b01, 25);
    wait_xy(0, V_ACTIVE);
    expect_paddle("pad_right1", 296);

    // reset during the SDRAM initial refresh burst
    key[0] = 1'b0;
    repeat (3) @(negedge clk);
    release_reset();
    while (cyc < 10020) @(negedge clk);
    check("sd_busy_before_reset", 32'(vif.dbg_sdram_state != 4'd0), 1);
    key[0] = 1'b0;
    #1;
    check("mid_rst_x", 32'(vif.outX), 0);
    check("mid_rst_y", 32'(vif.outY), 0);
    check("mid_rst_vga_clk", 32'(vif.VGA_CLK), 0);
    check("mid_rst_cmd", 32'(sd_cmd), 32'(CMD_NOP));
    check("mid_rst_sd_state", 32'(vif.dbg_sdram_state), 0);
    repeat (3) @(negedge clk);
    got_q.delete();
    got_t.delete();
    release_reset();

    // alternating presses, then a simultaneous press, leave the paddle at 288
    for (int i = 0; i < 10; i++) begin
      press(2'b01, 6);
      press(2'b10, 6);
    end
    press(2'b11, 6);
    wait_xy(0, V_ACTIVE);
    expect_paddle("pad_alternate", 288);

    for (int i = 0; i < 40; i++) press(2'b10, 6);
    wait_xy(0, V_ACTIVE);
    expect_paddle("pad_left_sat", 0);

    for (int i = 0; i < 100; i++) press(2'b01, 6);
    wait_xy(0, V_ACTIVE);
    expect_paddle("pad_right_sat", 576);

    // the SDRAM sequence restarted with the full wait
    check("sd_restart_seen", 32'(got_q.size() > 0), 1);
    if (got_q.size() > 0) begin
      check("sd_restart_cmd", 32'(got_q[0]), 32'({CMD_PRE, 13'h0400}));
      check("sd_restart_time", got_t[0], 10000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/modulo_vga_controller.md
Name: modulo_vga_controller

Overview:
Top-level display block for the FPGA game platform. It generates 640x480@60 Hz VGA timing from a 50 MHz clock and renders a background with a horizontally movable paddle, steered by two push-buttons. It also keeps the external SDRAM initialised and refreshed, so a later framebuffer stage can use it without changing the pin-level interface.

Parameters:
H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (800 total)
V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (525 total)
PADDLE_W, 64, paddle width in pixels; paddle occupies lines 440..455
STEP, 8, pixels moved per key press
INIT_WAIT, 10000, SDRAM power-up NOP cycles (200 us at 50 MHz)
REFRESH_PERIOD, 390, clocks between auto-refreshes (7.8 us)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
KEY  in  3  KEY[0] = asynchronous active-low reset; KEY[1] = right button (active-low); KEY[2] = left button (active-low)
outRequest  out  1  high while the current pixel is in the active area (pixel-data request)
outX  out  10  current column 0..799
outY  out  10  current line 0..524
VGA_CLK  out  1  25 MHz pixel clock
VGA_HS, VGA_VS  out  1 each  syncs, active-low
VGA_BLANK_N  out  1  high in the active area
VGA_SYNC_N  out  1  constant 0
VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
DRAM_CLK  out  1  inverted CLOCK_50
DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  out  1 each  SDRAM control
DRAM_ADDR  out  13; DRAM_BA  out  2; DRAM_DQM  out  2; DRAM_DQ  inout  16

Behaviour:
- One clock domain (CLOCK_50). The design has a single clock and an asynchronous, active-low reset: KEY[0].
- VGA_CLK toggles every CLOCK_50 cycle. The pixel-enable is the cycle in which VGA_CLK goes 1->0.
- Counters advance on the pixel-enable. outX wraps 799->0 and increments outY; outY wraps 524->0.
- Reset values: outX=0, outY=0, VGA_CLK=0, paddle X=288.
- VGA_HS is low for outX in 656..751. VGA_VS is low for outY in 490..491.
- VGA_BLANK_N = outRequest = (outX<640 && outY<480).
- Colour is combinational from registered outX/outY:
  - Outside the active area: 0,0,0.
  - Paddle pixel (outY in 440..455, outX in [paddleX, paddleX+PADDLE_W-1]): FF,FF,FF.
  - Otherwise: 00,00,80.
- Keys:
  - Each key passes through a 2-FF synchroniser. A falling edge (press) produces one move request.
  - Right request: target = min(target+STEP, 640-PADDLE_W). Left request: target = max(target-STEP, 0). Saturation is computed without wrap.
  - If both requests occur in the same cycle, the target is unchanged.
  - paddleX <= target on the pixel-enable where outX=0 and outY=480 (start of vertical blank), so a frame never tears.
- SDRAM state machine, states INIT_WAIT -> PRECHARGE -> WAIT_RP -> REFRESH(x8, 7-clock tRC each) -> LOAD_MODE -> WAIT_MRD -> IDLE <-> AUTO_REFRESH:
  - Command encoding {CS_N,RAS_N,CAS_N,WE_N}: NOP=0111, PRECHARGE ALL=0010 with ADDR[10]=1, REFRESH=0001, LOAD MODE=0000 with ADDR=13'h030 (CL3, BL1, sequential).
  - tRP = 3 clocks; tMRD = 2 clocks. Every command lasts one clock; NOP otherwise.
  - In IDLE, REFRESH is issued every REFRESH_PERIOD clocks.
- SDRAM static outputs: CKE=1 from reset, BA=0, DQM=2'b11, DQ always high-Z.
- Reset asserted mid-operation: everything returns to its reset state immediately. The SDRAM sequence restarts from INIT_WAIT and outputs NOP.

Test Plan:
- Release reset at 100 ns -> first hsync low at outX=656 of line 0. The line period is 1600 CLOCK_50 cycles (32 us) and the frame period is 16.8 ms. VGA_BLANK_N stays low for outX>=640.
- After reset, hold 200 us -> one PRECHARGE (ADDR[10]=1), 8 REFRESH, then LOAD MODE with ADDR=13'h030. After that, a REFRESH every 390 clocks and DQ is high-Z throughout.
- At 400 us, press right (KEY[1] low for 500 ns) -> after the next vertical-blank start, paddleX=296 and pixel (296,440) is white while (295,440) is blue.
- Alternate right then left presses 10 times -> final paddleX=288.
- Press left 40 times from reset -> paddleX saturates at 0. Press right 100 times -> paddleX saturates at 576.
- Assert KEY[0] low during the SDRAM refresh phase -> counters return to 0, the SDRAM outputs NOP, and the sequence restarts with the 10000-cycle wait.
